// File: rtl/npu_job_sequencer.sv
// Job sequencer for the NPU compute datapath: per tile, LOAD/COMPUTE over K steps, then STORE.
// Optional perf_cycles output is built when NPU_SEQ_PERF_CNT_EN is defined.
module npu_job_sequencer #(
  parameter int TILE_W  = 8,
  parameter int K_W     = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // Handshakes: cfg uses valid/ready, a job is accepted on a cycle with
  // cfg_valid && cfg_ready; engines use a one-cycle start pulse and a done pulse.
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [K_W-1:0]    cfg_k_steps,
  input  logic              abort,
  output logic              load_start,
  input  logic              load_done,
  output logic              mac_clear,
  output logic              mac_start,
  input  logic              mac_done,
  output logic              store_start,
  input  logic              store_done,
  output logic [TILE_W-1:0] tile_idx,
  output logic [K_W-1:0]    k_idx,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef NPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_STORE   = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [K_W:0]      K_ONE    = (K_W + 1)'(1);
  localparam logic [TILE_W:0]   TILE_ONE = (TILE_W + 1)'(1);

  state_e              state_q, state_d;
  logic [TILE_W-1:0]   tiles_q, tiles_d;
  logic [K_W-1:0]      k_steps_q, k_steps_d;
  logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
  logic [K_W-1:0]      k_idx_q, k_idx_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                err_q, err_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                busy_q, busy_d;
  logic                load_start_q, load_start_d;
  logic                mac_clear_q, mac_clear_d;
  logic                mac_start_q, mac_start_d;
  logic                store_start_q, store_start_d;
  logic                done_q, done_d;
  logic                timeout;
  logic                entering;

`ifdef NPU_SEQ_PERF_CNT_EN
  logic [31:0]         perf_cnt_q, perf_cnt_d;
  logic [31:0]         perf_cycles_q, perf_cycles_d;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tiles_q       <= '0;
      k_steps_q     <= '0;
      tile_idx_q    <= '0;
      k_idx_q       <= '0;
      wd_q          <= '0;
      err_q         <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      load_start_q  <= 1'b0;
      mac_clear_q   <= 1'b0;
      mac_start_q   <= 1'b0;
      store_start_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef NPU_SEQ_PERF_CNT_EN
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tiles_q       <= tiles_d;
      k_steps_q     <= k_steps_d;
      tile_idx_q    <= tile_idx_d;
      k_idx_q       <= k_idx_d;
      wd_q          <= wd_d;
      err_q         <= err_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      load_start_q  <= load_start_d;
      mac_clear_q   <= mac_clear_d;
      mac_start_q   <= mac_start_d;
      store_start_q <= store_start_d;
      done_q        <= done_d;
`ifdef NPU_SEQ_PERF_CNT_EN
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
`endif
    end
  end

  assign timeout = (wd_q == WD_LAST);

  // Next-state logic. A done pulse is honoured only after the start-pulse cycle.
  always_comb begin
    state_d    = state_q;
    tiles_d    = tiles_q;
    k_steps_d  = k_steps_q;
    tile_idx_d = tile_idx_q;
    k_idx_d    = k_idx_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          tiles_d    = cfg_tiles;
          k_steps_d  = cfg_k_steps;
          tile_idx_d = '0;
          k_idx_d    = '0;
          if ((cfg_tiles == '0) || (cfg_k_steps == '0)) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_done && !load_start_q) begin
          state_d = ST_COMPUTE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_COMPUTE: begin
        if (mac_done && !mac_start_q) begin
          if (({1'b0, k_idx_q} + K_ONE) < {1'b0, k_steps_q}) begin
            k_idx_d = k_idx_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_STORE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_STORE: begin
        if (store_done && !store_start_q) begin
          if (({1'b0, tile_idx_q} + TILE_ONE) < {1'b0, tiles_q}) begin
            tile_idx_d = tile_idx_q + 1'b1;
            k_idx_d    = '0;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_FINISH;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d    = ST_IDLE;
        tile_idx_d = '0;
        k_idx_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over any engine done or watchdog expiry in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tile_idx_d = '0;
      k_idx_d    = '0;
      err_d      = err_q;
    end
  end

  // Output logic: every output is registered from its next-state value.
  always_comb begin
    entering      = (state_d != state_q);
    wd_d          = entering ? '0 : (wd_q + 1'b1);
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end
    cfg_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    load_start_d  = entering && (state_d == ST_LOAD);
    mac_clear_d   = entering && (state_d == ST_LOAD) && (k_idx_d == '0);
    mac_start_d   = entering && (state_d == ST_COMPUTE);
    store_start_d = entering && (state_d == ST_STORE);
    done_d        = entering && (state_d == ST_FINISH);
  end

`ifdef NPU_SEQ_PERF_CNT_EN
  // Cycle count runs from the accept cycle; the FINISH cycle itself is added on latch.
  always_comb begin
    perf_cnt_d    = perf_cnt_q;
    perf_cycles_d = perf_cycles_q;
    if (state_q == ST_IDLE) begin
      if (cfg_valid && cfg_ready_q) begin
        perf_cnt_d = 32'd1;
      end
    end else if (perf_cnt_q != '1) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
    if ((state_q == ST_FINISH) && !abort) begin
      perf_cycles_d = (perf_cnt_q == '1) ? perf_cnt_q : (perf_cnt_q + 32'd1);
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign load_start  = load_start_q;
  assign mac_clear   = mac_clear_q;
  assign mac_start   = mac_start_q;
  assign store_start = store_start_q;
  assign done        = done_q;
  assign err         = err_q;
  assign tile_idx    = tile_idx_q;
  assign k_idx       = k_idx_q;

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Self-checking bench for npu_job_sequencer: directed timing cases plus randomized jobs
// checked against an expected start-event queue built from the job's tile/K loops.
module tb_npu_job_sequencer;
  localparam int TILE_W  = 8;
  localparam int K_W     = 8;
  localparam int TIMEOUT = 16;
  localparam int EV_W    = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [TILE_W-1:0] cfg_tiles = '0;
  logic [K_W-1:0]    cfg_k_steps = '0;
  logic              abort = 1'b0;
  logic              load_start, mac_clear, mac_start, store_start;
  logic              load_done = 1'b0, mac_done = 1'b0, store_done = 1'b0;
  logic [TILE_W-1:0] tile_idx;
  logic [K_W-1:0]    k_idx;
  logic              busy, done, err;
`ifdef NPU_SEQ_PERF_CNT_EN
  logic [31:0]       perf_cycles;
`endif

  npu_job_sequencer #(.TILE_W(TILE_W), .K_W(K_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tiles(cfg_tiles), .cfg_k_steps(cfg_k_steps),
    .abort(abort),
    .load_start(load_start), .load_done(load_done),
    .mac_clear(mac_clear), .mac_start(mac_start), .mac_done(mac_done),
    .store_start(store_start), .store_done(store_done),
    .tile_idx(tile_idx), .k_idx(k_idx),
    .busy(busy), .done(done), .err(err)
`ifdef NPU_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [EV_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic accept(input int t, input int k);
    check("accept_ready", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_tiles = TILE_W'(t);
    cfg_k_steps = K_W'(k);
    step();
    cfg_valid = 1'b0;
  endtask

  function automatic logic [EV_W-1:0] mk_ev(input int ty, input bit clr, input int t, input int k);
    logic [1:0] ty2;
    logic [TILE_W-1:0] t8;
    logic [K_W-1:0] k8;
    ty2 = 2'(ty);
    t8 = TILE_W'(t);
    k8 = K_W'(k);
    return {ty2, clr, t8, k8};
  endfunction

  task automatic build_expected(input int tiles, input int ks);
    exp_q.delete();
    for (int t = 0; t < tiles; t++) begin
      for (int k = 0; k < ks; k++) begin
        exp_q.push_back(mk_ev(1, k == 0, t, k));
        exp_q.push_back(mk_ev(2, 1'b0, t, k));
      end
      exp_q.push_back(mk_ev(3, 1'b0, t, ks - 1));
    end
  endtask

  // Engine responder: answers each start pulse after 1..4 cycles, sometimes raises an
  // ignorable done coincident with the start or from the wrong engine.
  task automatic run_body(input int budget, output bit got_done);
    int next_exp;
    int pend;
    int due;
    int ty;
    logic [EV_W-1:0] ev;
    next_exp = cyc;
    pend = 0;
    due = -1;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      load_done = 1'b0; mac_done = 1'b0; store_done = 1'b0;
      if (load_start || mac_start || store_start) begin
        ty = load_start ? 1 : (mac_start ? 2 : 3);
        ev = mk_ev(ty, mac_clear, int'(tile_idx), int'(k_idx));
        if (exp_q.size() == 0) check("extra_start", {13'd0, ev}, 32'd0);
        else check("start_event", {13'd0, ev}, {13'd0, exp_q.pop_front()});
        check("start_time", cyc, next_exp);
        pend = ty;
        due = cyc + $urandom_range(1, 4);
        if ($urandom_range(0, 2) == 0) begin
          load_done = (ty == 1); mac_done = (ty == 2); store_done = (ty == 3);
        end
      end else if (pend != 0 && cyc == due) begin
        load_done = (pend == 1); mac_done = (pend == 2); store_done = (pend == 3);
        next_exp = cyc + 1;
        pend = 0;
      end else if (pend != 0 && $urandom_range(0, 3) == 0) begin
        load_done = (pend != 1); mac_done = (pend == 1); store_done = 1'b0;
      end
      if (done) begin
        check("done_time", cyc, next_exp);
        got_done = 1'b1;
        break;
      end
      step();
    end
    load_done = 1'b0; mac_done = 1'b0; store_done = 1'b0;
  endtask

  task automatic run_auto_job(input int tiles, input int ks);
    bit got;
    build_expected(tiles, ks);
    accept(tiles, ks);
    run_body(20 * tiles * (2 * ks + 1) + 40, got);
    check("job_done", {31'd0, got}, 32'd1);
    check("job_events_left", exp_q.size(), 32'd0);
    check("job_err", {31'd0, err}, 32'd0);
    step();
    check("job_single_done", {31'd0, done}, 32'd0);
    check("job_idle", {31'd0, cfg_ready}, 32'd1);
  endtask

  initial begin
    bit got;
    int s;
    int seen;
    // Reset block
    repeat (3) step();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {28'd0, load_start, mac_clear, mac_start, store_start}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_idx", {16'd0, tile_idx, k_idx}, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Abort in IDLE is ignored
    abort = 1'b1; step(); abort = 1'b0;
    check("idle_abort_ready", {31'd0, cfg_ready}, 32'd1);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Single tile exact timing (T+1 .. T+11)
    accept(1, 1);
    check("st_ls", {30'd0, load_start, mac_clear}, 32'd3);
    check("st_busy", {30'd0, busy, cfg_ready}, 32'd2);
    step(); check("st_ls_pulse", {31'd0, load_start}, 32'd0);
    step(); load_done = 1'b1;
    step(); load_done = 1'b0;
    check("st_ms", {30'd0, mac_start, mac_clear}, 32'd2);
    step(); step(); mac_done = 1'b1;
    step(); mac_done = 1'b0;
    check("st_ss", {31'd0, store_start}, 32'd1);
    step(); step(); store_done = 1'b1;
    step(); store_done = 1'b0;
    check("st_done", {30'd0, done, err}, 32'd2);
    step();
    check("st_after", {29'd0, done, busy, cfg_ready}, 32'd1);
`ifdef NPU_SEQ_PERF_CNT_EN
    check("st_perf", perf_cycles, 32'd11);
`endif

    // Watchdog: mac_done never comes
    accept(1, 1);
    step(); load_done = 1'b1;
    step(); load_done = 1'b0;
    check("wd_ms", {31'd0, mac_start}, 32'd1);
    s = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) break;
    end
    check("wd_latency", cyc - s, TIMEOUT);
    check("wd_err", {30'd0, done, err}, 32'd3);
    step();
    check("wd_idle_err", {30'd0, cfg_ready, err}, 32'd3);
    accept(1, 1);
    check("wd_err_clear", {31'd0, err}, 32'd0);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_load_busy", {30'd0, busy, done}, 32'd0);

    // Abort during STORE with a coincident store_done
    accept(2, 1);
    step(); load_done = 1'b1;
    step(); load_done = 1'b0;
    check("ab_ms", {31'd0, mac_start}, 32'd1);
    step(); mac_done = 1'b1;
    step(); mac_done = 1'b0;
    check("ab_ss", {31'd0, store_start}, 32'd1);
    step(); store_done = 1'b1; abort = 1'b1;
    step(); store_done = 1'b0; abort = 1'b0;
    check("ab_state", {28'd0, busy, cfg_ready, done, load_start}, 32'd4);
    check("ab_idx", {16'd0, tile_idx, k_idx}, 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen += int'(done) + int'(load_start);
    end
    check("ab_quiet", seen, 32'd0);

    // Zero counts
    accept(0, 3);
    check("z0_done", {28'd0, done, err, load_start, busy}, 32'd13);
    step();
    check("z0_after", {29'd0, done, cfg_ready, err}, 32'd3);
`ifdef NPU_SEQ_PERF_CNT_EN
    check("z0_perf", perf_cycles, 32'd2);
`endif
    accept(2, 0);
    check("z1_done", {29'd0, done, err, load_start}, 32'd6);
    step();

    // Early load_done and cfg_valid while busy
    accept(1, 2);
    load_done = 1'b1; cfg_valid = 1'b1; cfg_tiles = 8'd5; cfg_k_steps = 8'd5;
    step(); load_done = 1'b0;
    check("early_ms", {31'd0, mac_start}, 32'd0);
    step();
    check("early_wait", {30'd0, mac_start, busy}, 32'd1);
    load_done = 1'b1;
    step(); load_done = 1'b0; cfg_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk_ev(2, 1'b0, 0, 0));
    exp_q.push_back(mk_ev(1, 1'b0, 0, 1));
    exp_q.push_back(mk_ev(2, 1'b0, 0, 1));
    exp_q.push_back(mk_ev(3, 1'b0, 0, 1));
    run_body(200, got);
    check("early_job_done", {31'd0, got}, 32'd1);
    check("early_events_left", exp_q.size(), 32'd0);
    step();

    // Async reset mid-job
    accept(2, 2);
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_state", {28'd0, busy, cfg_ready, done, err}, 32'd4);
    step(); rst = 1'b0; step();

    // Randomized and boundary jobs
    run_auto_job(2, 3);
    for (int j = 0; j < 8; j++) run_auto_job($urandom_range(1, 3), $urandom_range(1, 3));
    run_auto_job(1, 255);
    run_auto_job(255, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
